// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types, constants and arithmetic helpers for systolic_mm.
// Holds the data width, FSM state encodings, the FP32 zero constant, the
// combinational single-precision multiply/add used by every PE, and the ReLU helpers.
package systolic_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0;

  // Single-precision multiply, round-to-nearest-even. Subnormal inputs and
  // results are flushed to signed zero; overflow saturates to infinity.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    logic [24:0] sig;
    logic        rnd;
    logic        stk;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    // Product of two [1,2) significands lies in [1,4); normalise to bit 47.
    if (p[47]) e = e + 1;
    else       p = p << 1;
    sig = {1'b0, p[47:24]};
    rnd = p[23];
    stk = |p[22:0];
    if (rnd && (stk || sig[0])) sig = sig + 25'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  // Single-precision add, round-to-nearest-even, same flushing rules as fp_mul.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big;
    logic [31:0] sml;
    logic [50:0] mb;
    logic [50:0] ms;
    logic [50:0] sum;
    logic [50:0] norm;
    logic [24:0] sig;
    logic        rnd;
    logic        stk;
    int          d;
    int          msb;
    int          e;
    if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? {x[31] & y[31], 31'd0} : y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    // Leading one at bit 49; bit 50 catches the carry; 26 guard bits below.
    mb = {1'b0, 1'b1, big[22:0], 26'd0};
    ms = {1'b0, 1'b1, sml[22:0], 26'd0};
    d  = int'(big[30:23]) - int'(sml[30:23]);
    if (d > 49) begin
      ms = 51'd1;
    end else begin
      norm = ms >> d;
      // Bits shifted out still matter for rounding: fold them into a sticky lsb.
      if ((norm << d) != ms) norm[0] = 1'b1;
      ms = norm;
    end
    sum = (big[31] ^ sml[31]) ? (mb - ms) : (mb + ms);
    if (sum == '0) return FP_ZERO;
    msb = 0;
    for (int i = 0; i < 51; i++) begin
      if (sum[i]) msb = i;
    end
    e    = int'(big[30:23]) + msb - 49;
    norm = sum << (50 - msb);
    sig  = {1'b0, norm[50:27]};
    rnd  = norm[26];
    stk  = |norm[25:0];
    if (rnd && (stk || sig[0])) sig = sig + 25'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e <= 0)   return {big[31], 31'd0};
    if (e >= 255) return {big[31], 8'hFF, 23'd0};
    return {big[31], e[7:0], sig[22:0]};
  endfunction

  // Strictly positive: sign clear and not zero, so -0.0 and +0.0 both give 0.
  function automatic logic fp_pos(input logic [31:0] v);
    return !v[31] && (v[30:0] != 31'd0);
  endfunction

  function automatic logic [31:0] fp_relu(input logic [31:0] v);
    return fp_pos(v) ? v : FP_ZERO;
  endfunction

endpackage

// File: rtl/systolic_mm_pe.sv
// sa_pe: one output-stationary processing element of the systolic grid.
// Ports: a/a_valid from the left and b/b_valid from the top, forwarded registered
// to the right (a_pass*) and bottom (b_pass*); clear/capture/shift control the
// accumulator and its shadow, which shifts left via shadow_next -> shadow.
module sa_pe
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] b,
  input  logic              b_valid,
  output logic [DATA_W-1:0] a_pass,
  output logic              a_pass_valid,
  output logic [DATA_W-1:0] b_pass,
  output logic              b_pass_valid,
  input  logic              capture,
  input  logic              shift,
  input  logic [DATA_W-1:0] shadow_next,
  output logic [DATA_W-1:0] shadow
);

  logic [DATA_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_pass       <= FP_ZERO;
      a_pass_valid <= 1'b0;
      b_pass       <= FP_ZERO;
      b_pass_valid <= 1'b0;
      acc          <= FP_ZERO;
      shadow       <= FP_ZERO;
    end else begin
      a_pass       <= a;
      a_pass_valid <= a_valid;
      b_pass       <= b;
      b_pass_valid <= b_valid;
      if (clear) begin
        acc <= FP_ZERO;
      end else if (a_valid && b_valid) begin
        acc <= fp_add(acc, fp_mul(a, b));
      end
      // The drain only ever touches the shadow, so accumulators survive for cfg_acc jobs.
      if (capture) begin
        shadow <= acc;
      end else if (shift) begin
        shadow <= shadow_next;
      end
    end
  end

endmodule

// File: rtl/systolic_mm.sv
// systolic_mm: ROWS x COLS output-stationary FP32 matrix-multiply engine with input
// skew, job FSM (IDLE/LOAD/FLUSH/DRAIN), fused ReLU/mask output and accumulate-across-jobs.
// Ports: start/cfg_* launch a job; in_valid/in_ready carry a_vec/b_vec operand beats;
// out_valid/out_ready carry out_vec/out_mask result columns; busy and done report status.
module systolic_mm
  import systolic_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int K_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K_W-1:0]         cfg_k,
  input  logic                   cfg_relu,
  input  logic                   cfg_acc,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*DATA_W-1:0] out_vec,
  output logic [ROWS-1:0]        out_mask,
  output logic                   busy,
  output logic                   done
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam int DW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [FW-1:0] FLUSH_LEN = FW'(ROWS + COLS - 1);

  logic [1:0]    state;
  logic [K_W-1:0] beat_cnt;
  logic [K_W-1:0] k_q;
  logic          relu_q;
  logic [FW-1:0] flush_cnt;
  logic [DW-1:0] drain_cnt;

  logic accept;
  logic clear;
  logic capture;
  logic shift;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign clear     = (state == IDLE) && start && !cfg_acc;
  assign capture   = (state == FLUSH) && (flush_cnt == FW'(1));
  assign shift     = out_valid && out_ready;

  // Job FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      k_q       <= '0;
      relu_q    <= 1'b0;
      flush_cnt <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q       <= cfg_k;
            relu_q    <= cfg_relu;
            beat_cnt  <= '0;
            flush_cnt <= FLUSH_LEN;
            state     <= (cfg_k == '0) ? FLUSH : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt == k_q - K_W'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          // Long enough for the last beat to reach PE(ROWS-1, COLS-1).
          if (flush_cnt == FW'(1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (drain_cnt == DW'(COLS - 1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skewed lanes feeding the array edges; the valid tag travels with the data
  // so bubbles are carried through instead of stalling the array.
  logic [DATA_W-1:0] a_lane   [ROWS];
  logic              a_lane_v [ROWS];
  logic [DATA_W-1:0] b_lane   [COLS];
  logic              b_lane_v [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_lane[r]   = a_vec[r*DATA_W +: DATA_W];
      assign a_lane_v[r] = accept;
    end else begin : g_dly
      logic [DATA_W-1:0] d  [r];
      logic              dv [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < r; j++) begin
            d[j]  <= FP_ZERO;
            dv[j] <= 1'b0;
          end
        end else begin
          d[0]  <= a_vec[r*DATA_W +: DATA_W];
          dv[0] <= accept;
          for (int j = 1; j < r; j++) begin
            d[j]  <= d[j-1];
            dv[j] <= dv[j-1];
          end
        end
      end
      assign a_lane[r]   = d[r-1];
      assign a_lane_v[r] = dv[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_lane[c]   = b_vec[c*DATA_W +: DATA_W];
      assign b_lane_v[c] = accept;
    end else begin : g_dly
      logic [DATA_W-1:0] d  [c];
      logic              dv [c];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < c; j++) begin
            d[j]  <= FP_ZERO;
            dv[j] <= 1'b0;
          end
        end else begin
          d[0]  <= b_vec[c*DATA_W +: DATA_W];
          dv[0] <= accept;
          for (int j = 1; j < c; j++) begin
            d[j]  <= d[j-1];
            dv[j] <= dv[j-1];
          end
        end
      end
      assign b_lane[c]   = d[c-1];
      assign b_lane_v[c] = dv[c-1];
    end
  end

  // PE grid. ah/bv carry operands horizontally/vertically; sh is the shadow
  // chain, with a zero fed in past the last column.
  logic [DATA_W-1:0] ah  [ROWS][COLS+1];
  logic              ahv [ROWS][COLS+1];
  logic [DATA_W-1:0] bv  [ROWS+1][COLS];
  logic              bvv [ROWS+1][COLS];
  logic [DATA_W-1:0] sh  [ROWS][COLS+1];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign ah[r][0]    = a_lane[r];
    assign ahv[r][0]   = a_lane_v[r];
    assign sh[r][COLS] = FP_ZERO;

    logic unused_a_edge;
    assign unused_a_edge = ^{ah[r][COLS], ahv[r][COLS]};

    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe u_pe (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .a            (ah[r][c]),
        .a_valid      (ahv[r][c]),
        .b            (bv[r][c]),
        .b_valid      (bvv[r][c]),
        .a_pass       (ah[r][c+1]),
        .a_pass_valid (ahv[r][c+1]),
        .b_pass       (bv[r+1][c]),
        .b_pass_valid (bvv[r+1][c]),
        .capture      (capture),
        .shift        (shift),
        .shadow_next  (sh[r][c+1]),
        .shadow       (sh[r][c])
      );
    end

    assign out_vec[r*DATA_W +: DATA_W] = relu_q ? fp_relu(sh[r][0]) : sh[r][0];
    assign out_mask[r]                 = fp_pos(sh[r][0]);
  end

  for (genvar c = 0; c < COLS; c++) begin : g_colin
    assign bv[0][c]  = b_lane[c];
    assign bvv[0][c] = b_lane_v[c];

    logic unused_b_edge;
    assign unused_b_edge = ^{bv[ROWS][c], bvv[ROWS][c]};
  end

endmodule

// File: tb/tb_systolic_mm.sv
// tb_systolic_mm: 2x2 directed bench for systolic_mm with a scoreboard queue.
// Jobs push their expected result beats; a negedge monitor pops and compares
// on each out_valid && out_ready handshake.
module tb_systolic_mm;

  localparam logic [31:0] F0  = 32'h00000000;
  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F8  = 32'h41000000;
  localparam logic [31:0] FM1 = 32'hBF800000;
  localparam logic [31:0] FM4 = 32'hC0800000;

  // Operand beats: {lane1, lane0}
  localparam logic [63:0] ID_A0 = {F3, F1};   // column 0 of A = [[1,2],[3,4]]
  localparam logic [63:0] ID_A1 = {F4, F2};
  localparam logic [63:0] ID_B0 = {F0, F1};   // rows of identity
  localparam logic [63:0] ID_B1 = {F1, F0};
  localparam logic [63:0] RL_A0 = {F3, FM1};  // A = [[-1,2],[3,-4]]
  localparam logic [63:0] RL_A1 = {FM4, F2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_k = 8'd0;
  logic        cfg_relu = 1'b0;
  logic        cfg_acc = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_vec = 64'd0;
  logic [63:0] b_vec = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_vec;
  logic [1:0]  out_mask;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          fails = 0;
  int          job_cyc = 0;
  logic [65:0] sb [$];
  logic [65:0] mon_exp;

  systolic_mm #(.ROWS(2), .COLS(2), .K_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_k     (cfg_k),
    .cfg_relu  (cfg_relu),
    .cfg_acc   (cfg_acc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_mask  (out_mask),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] vec, input logic [1:0] mask);
    sb.push_back({mask, vec});
  endtask

  task automatic tick();
    @(posedge clk);
    job_cyc++;
    #1;
  endtask

  // Monitor: every result handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got beat %h with no expected beat queued", out_vec);
      end else begin
        mon_exp = sb.pop_front();
        check("out_vec", out_vec, mon_exp[63:0]);
        check("out_mask", 64'(out_mask), 64'(mon_exp[65:64]));
      end
    end
  end

  // Runs one job of up to two beats. gap = bubble cycles between beats,
  // stall = cycles out_ready is held low once beat0 appears, exp_cyc = expected
  // edges from the start edge to done (0 = not checked).
  task automatic run_job(input int k, input logic relu, input logic acc,
                         input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1,
                         input int gap, input int stall, input logic [63:0] hold,
                         input int exp_cyc);
    @(posedge clk);
    #1;
    start     = 1'b1;
    cfg_k     = 8'(k);
    cfg_relu  = relu;
    cfg_acc   = acc;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    job_cyc  = 0;
    start    = 1'b0;
    cfg_k    = 8'd0;
    cfg_relu = ~relu;
    cfg_acc  = ~acc;
    for (int i = 0; i < k; i++) begin
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          if (g == 0) begin
            start = 1'b1;
            cfg_k = 8'd5;
          end
          @(negedge clk);
          check("bubble_in_ready", 64'(in_ready), 64'd1);
          tick();
          start = 1'b0;
        end
      end
      a_vec    = (i == 0) ? a0 : a1;
      b_vec    = (i == 0) ? b0 : b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    if (stall > 0) begin
      while (!out_valid && job_cyc < 100) tick();
      check("stall_out_valid", 64'(out_valid), 64'd1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_hold_vec", out_vec, hold);
        tick();
      end
      out_ready = 1'b1;
    end
    while (!done && job_cyc < 100) tick();
    check("done_seen", 64'(done), 64'd1);
    if (exp_cyc > 0) check("done_latency", 64'(job_cyc), 64'(exp_cyc));
    check("busy_at_done", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec", out_vec, 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Identity
    push({F3, F1}, 2'b11);
    push({F4, F2}, 2'b11);
    run_job(2, 1'b0, 1'b0, ID_A0, ID_B0, ID_A1, ID_B1, 0, 0, 64'd0, 7);

    // Bubbles, with an ignored start inside the gap
    push({F3, F1}, 2'b11);
    push({F4, F2}, 2'b11);
    run_job(2, 1'b0, 1'b0, ID_A0, ID_B0, ID_A1, ID_B1, 3, 0, 64'd0, 10);

    // Backpressure on beat0
    push({F3, F1}, 2'b11);
    push({F4, F2}, 2'b11);
    run_job(2, 1'b0, 1'b0, ID_A0, ID_B0, ID_A1, ID_B1, 0, 4, {F3, F1}, 11);

    // ReLU
    push({F3, F0}, 2'b10);
    push({F0, F2}, 2'b01);
    run_job(2, 1'b1, 1'b0, RL_A0, ID_B0, RL_A1, ID_B1, 0, 0, 64'd0, 7);

    // Accumulate: fresh identity, then accumulate, then K=0 accumulate
    push({F3, F1}, 2'b11);
    push({F4, F2}, 2'b11);
    run_job(2, 1'b0, 1'b0, ID_A0, ID_B0, ID_A1, ID_B1, 0, 0, 64'd0, 7);
    push({F6, F2}, 2'b11);
    push({F8, F4}, 2'b11);
    run_job(2, 1'b0, 1'b1, ID_A0, ID_B0, ID_A1, ID_B1, 0, 0, 64'd0, 7);
    push({F6, F2}, 2'b11);
    push({F8, F4}, 2'b11);
    run_job(0, 1'b0, 1'b1, ID_A0, ID_B0, ID_A1, ID_B1, 0, 0, 64'd0, 5);

    // Reset mid-LOAD after one beat
    @(posedge clk);
    #1;
    start   = 1'b1;
    cfg_k   = 8'd2;
    cfg_acc = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    a_vec    = ID_A0;
    b_vec    = ID_B0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_vec", out_vec, 64'd0);
    check("mid_rst_out_mask", 64'(out_mask), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Accumulating job after reset must see zeroed accumulators
    push({F3, F1}, 2'b11);
    push({F4, F2}, 2'b11);
    run_job(2, 1'b0, 1'b1, ID_A0, ID_B0, ID_A1, ID_B1, 0, 0, 64'd0, 7);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_mm.md
# systolic_mm

Parametrised ROWS×COLS output-stationary systolic matrix-multiply engine, the next generation of the fixed 8×8 MAC grid. It contains its own skew buffers, a bubble-tolerant valid pipeline, a job FSM and a drain shifter with ready/valid backpressure. Callers stream raw, unskewed operand vectors in and receive result columns out. It sits between the layer sequencer, which feeds activations and weights, and the activation writeback. It carries over the fused ReLU / ReLU-derivative output and adds accumulate-across-jobs.

## Interface
Parameters:
- ROWS, 8: array rows; number of A lanes and of output elements per beat.
- COLS, 8: array columns; number of B lanes and of output beats per job.
- K_W, 8: width of the depth counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  start pulse; accepted only in IDLE.
- cfg_k  in  K_W  number of operand beats K for the job; sampled at start.
- cfg_relu  in  1  apply ReLU to outputs; sampled at start.
- cfg_acc  in  1  keep the previous accumulators instead of clearing them; sampled at start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- a_vec  in  ROWS*32  column k of A; lane r = A[r][k].
- b_vec  in  COLS*32  row k of B; lane c = B[k][c].
- out_valid  out  1  result beat valid.
- out_ready  in  1  result beat consumed when out_valid && out_ready.
- out_vec  out  ROWS*32  column c of C; lane r = C[r][c], post-ReLU if cfg_relu.
- out_mask  out  ROWS  bit r = 1 iff pre-ReLU C[r][c] > 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result beat is consumed.

## Operation
- Arithmetic: 32-bit single-precision values, using the shared calc multiplier and adder, which are combinational. Each PE computes acc <= acc + a*b.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD on start.
  - If cfg_acc = 0, all accumulators are cleared to 0 in that same cycle.
  - If cfg_k = 0, go IDLE -> FLUSH directly.
- LOAD: in_ready = 1. A beat counter counts accepted beats; LOAD -> FLUSH in the cycle the K-th beat is accepted.
  - A cycle with in_valid = 0 injects a bubble: the data/valid tag travels through the array and no PE accumulates on it.
  - The array never freezes.
- Skewing:
  - A lane r passes through r register stages, then moves right one PE per cycle.
  - B lane c passes through c register stages, then moves down one PE per cycle.
  - Each lane carries a valid bit alongside its data.
  - PE(r,c) accumulates only when its incoming valid is 1.
- FLUSH: lasts exactly ROWS+COLS-1 cycles, counted down. On the last FLUSH cycle all accumulators are copied in parallel into the output shadow registers; then -> DRAIN.
- DRAIN:
  - out_vec/out_mask present shadow column 0.
  - Each handshake shifts every shadow row left by one position.
  - After COLS handshakes: done = 1, next state IDLE.
- Accumulate: with cfg_acc = 1, C_new = C_prev + A·B. Accumulators are never altered by the drain.
- ReLU: out_vec lane = (value > 0) ? value : 0. The comparison is on the sign bit and the value being nonzero; -0.0 maps to 0 with mask bit 0.

## Timing
- Reset values: in_ready 0, out_valid 0, out_vec 0, out_mask 0, busy 0, done 0; state IDLE; accumulators, shadows and skew registers all 0.
- Reset mid-job: the state returns to IDLE on the next edge, all state is lost, and no done pulse is issued.
- start while busy: ignored, with no effect on the running job.
- Product of beat k at PE(r,c) lands in acc at the edge (accept-cycle of beat k) + r + c + 1.
- out_valid rises the cycle after the last FLUSH cycle.
- Minimum job length, with no bubbles and out_ready tied high: K + (ROWS+COLS-1) + COLS cycles from the start edge to done.
- out_ready low: out_vec and out_mask hold stable and the shadows do not shift.
- done is asserted in the cycle following the final handshake, together with busy falling.

## Structure
- Package systolic_pkg holds:
  - DATA_W = 32.
  - The state enum {IDLE, LOAD, FLUSH, DRAIN}.
  - FP_ZERO = 32'h0.
  - The ReLU helper function.
- Sub-module sa_pe:
  - Inputs: a/a_valid and b/b_valid from the left and top; outputs the same pair to the right and bottom.
  - Holds the accumulator, a synchronous clear, and the capture-to-shadow shadow register with its left-shift input/output.
  - Instantiated ROWS×COLS via generate.
- The skew triangles and the FSM/counters live in the top module.

## Test plan
- Identity: ROWS=COLS=2, K=2, A=[[1,2],[3,4]], B=I (1.0 = 3F800000) -> beat0 {1.0, 3.0} = {3F800000, 40400000}, beat1 {2.0, 4.0}; done 2+3+2 cycles after start.
- Bubbles: same job with in_valid low for 3 cycles between the two beats -> identical out_vec; in_ready stays high across the gaps.
- Backpressure: out_ready held low for 4 cycles on beat0 -> out_vec held at {1.0, 3.0}, no shift occurs; beat1 follows correctly once out_ready rises.
- ReLU: A=[[-1,2],[3,-4]], B=I, cfg_relu=1 -> beat0 {0, 3.0}, mask 2'b10; beat1 {2.0, 0}, mask 2'b01.
- Accumulate: identity job run twice, second with cfg_acc=1 -> beat0 {2.0, 6.0}, beat1 {4.0, 8.0}. Then a cfg_k=0, cfg_acc=1 job -> same values again.
- Reset mid-LOAD after 1 beat -> all outputs 0 on the next cycle; a following identity job produces the clean result from test 1 with no residue.
